// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch hazards, memory-wait stalls with timeout.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  Rs1D,
   input  logic [5:0]  Rs2D,
   input  logic [5:0]  Rs1E,
   input  logic [5:0]  Rs2E,
   input  logic [5:0]  RdE,
   input  logic [5:0]  RdM,
   input  logic [5:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic        MemReqM,
   input  logic        MemReadyM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        MemTimeout,
   output logic [31:0] StallCnt,
   output logic [31:0] FlushCnt
);

   localparam logic [1:0]  ST_RUN    = 2'd0;
   localparam logic [1:0]  ST_WAIT   = 2'd1;
   localparam logic [1:0]  ST_TMO    = 2'd2;
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [15:0] wait_cnt_r;
   logic [15:0] wait_cnt_nxt_s;
   logic        mem_timeout_r;
   logic        mem_stall_s;
   logic        lw_stall_s;

   // Memory-stage producer wins over writeback; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [5:0] rs, input logic [5:0] rd_m,
                                          input logic we_m, input logic [5:0] rd_w,
                                          input logic we_w);
      if (we_m && (rd_m != 6'd0) && (rd_m == rs)) begin
         fwd_sel = 2'b10;
      end else if (we_w && (rd_w != 6'd0) && (rd_w == rs)) begin
         fwd_sel = 2'b01;
      end else begin
         fwd_sel = 2'b00;
      end
   endfunction

   // Operand forwarding selects
   always_comb begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

   // Hazard detection terms
   always_comb begin
      lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 6'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
      case (state_r)
         ST_RUN:  mem_stall_s = MemReqM && !MemReadyM;
         ST_WAIT: mem_stall_s = !MemReadyM;
         ST_TMO:  mem_stall_s = 1'b1;
         default: mem_stall_s = 1'b0;
      endcase
   end

   // Memory-wait FSM next state; a ready in the same RUN cycle as the request never leaves RUN
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         ST_RUN: begin
            if (MemReqM && !MemReadyM) begin
               state_nxt_s    = ST_WAIT;
               wait_cnt_nxt_s = 16'd1;
            end else begin
               state_nxt_s    = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (MemReadyM) begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = 16'd0;
            end else if (wait_cnt_r == TMO_LIMIT) begin
               state_nxt_s    = ST_TMO;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 16'd1;
            end
         end
         ST_TMO: begin
            state_nxt_s = ST_TMO;
         end
         default: begin
            state_nxt_s    = ST_RUN;
            wait_cnt_nxt_s = 16'd0;
         end
      endcase
   end

   // FSM state, wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_RUN;
         wait_cnt_r    <= 16'd0;
         mem_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         mem_timeout_r <= (state_nxt_s == ST_TMO);
      end
   end

   assign MemTimeout = mem_timeout_r;

   // Stall/flush outputs; a branch seen during a memory stall stays held in E until the stall clears
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mem_stall_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall_s) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else begin
         FlushW = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Free-running performance counters, wrapping at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (StallF || StallD || StallE || StallM) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (FlushD || FlushE) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign StallCnt = stall_cnt_r;
   assign FlushCnt = flush_cnt_r;
`else
   assign StallCnt = 32'd0;
   assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational cases plus memory-wait, branch-hold,
// timeout and reset sequences, compared through an expected-result queue.
module tb_hazard_ctrl;

   typedef struct {
      string       name;
      logic [5:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic        rwm, rww;
      logic [1:0]  rsrc;
      logic        pc, req, rdy, rst;
      logic [11:0] exp;
   } vec_t;

   // {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, MemTimeout}
   localparam logic [11:0] E_NONE = 12'b0000_000_00_00_0;
   localparam logic [11:0] E_LW   = 12'b1100_010_00_00_0;
   localparam logic [11:0] E_BR   = 12'b0000_110_00_00_0;
   localparam logic [11:0] E_MEM  = 12'b1111_001_00_00_0;
   localparam logic [11:0] E_TMO  = 12'b1111_001_00_00_1;

   logic        clk, rst_n;
   logic [5:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
   logic [1:0]  ResultSrcE;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [31:0] StallCnt, FlushCnt;

   int   total = 0;
   int   bad   = 0;
   logic [31:0] exp_sc = 32'd0;
   logic [31:0] exp_fc = 32'd0;
   vec_t sb[$];
   vec_t tbl[$];

   hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string n,
                               input logic [5:0] rs1d, input logic [5:0] rs2d,
                               input logic [5:0] rs1e, input logic [5:0] rs2e,
                               input logic [5:0] rde, input logic [5:0] rdm, input logic [5:0] rdw,
                               input logic rwm, input logic rww, input logic [1:0] rsrc,
                               input logic pc, input logic req, input logic rdy, input logic rst,
                               input logic [11:0] exp);
      vec_t v;
      v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
      v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww; v.rsrc = rsrc;
      v.pc = pc; v.req = req; v.rdy = rdy; v.rst = rst; v.exp = exp;
      return v;
   endfunction

   // Idle-operand shorthand for control-only sequences
   function automatic vec_t mc(input string n, input logic pc, input logic req, input logic rdy,
                               input logic rst, input logic [11:0] exp);
      return mk(n, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00,
                pc, req, rdy, rst, exp);
   endfunction

   // One clock cycle: drive after the rising edge, compare on the falling edge
   task automatic step(input vec_t v);
      vec_t e;
      logic [11:0] act;
      rst_n = ~v.rst;
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
      RdE = v.rde; RdM = v.rdm; RdW = v.rdw; RegWriteM = v.rwm; RegWriteW = v.rww;
      ResultSrcE = v.rsrc; PCSrcE = v.pc; MemReqM = v.req; MemReadyM = v.rdy;
      if (v.rst) begin
         exp_sc = 32'd0;
         exp_fc = 32'd0;
      end
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemTimeout};
      total++;
      if (act !== e.exp) begin
         bad++;
         $display("FAIL %s: outputs got %b want %b", e.name, act, e.exp);
      end
      total++;
      if ((StallCnt !== exp_sc) || (FlushCnt !== exp_fc)) begin
         bad++;
         $display("FAIL %s_cnt: stall/flush cnt got %0d/%0d want %0d/%0d",
                  e.name, StallCnt, FlushCnt, exp_sc, exp_fc);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!e.rst) begin
         if (|e.exp[11:8]) exp_sc = exp_sc + 32'd1;
         if (|e.exp[7:6])  exp_fc = exp_fc + 32'd1;
      end
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      Rs1D = 6'd0; Rs2D = 6'd0; Rs1E = 6'd0; Rs2E = 6'd0; RdE = 6'd0; RdM = 6'd0; RdW = 6'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00;
      PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;

      //        name        rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   rwm   rww   rsrc   pc    req   rdy   rst
      tbl.push_back(mk("reset",  6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, E_NONE));
      tbl.push_back(mk("idle",   6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      tbl.push_back(mk("fwd_mw", 6'd0, 6'd0, 6'd5, 6'd5, 6'd0, 6'd5, 6'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {7'b0, 2'b10, 2'b10, 1'b0}));
      tbl.push_back(mk("fwd_ab", 6'd0, 6'd0, 6'd5, 6'd6, 6'd0, 6'd5, 6'd6, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {7'b0, 2'b10, 2'b01, 1'b0}));
      tbl.push_back(mk("fwd_rd0",6'd5, 6'd0, 6'd5, 6'd6, 6'd0, 6'd0, 6'd6, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {7'b0, 2'b00, 2'b01, 1'b0}));
      tbl.push_back(mk("fwd_x0", 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      tbl.push_back(mk("fwd_w",  6'd0, 6'd0, 6'd3, 6'd3, 6'd0, 6'd3, 6'd3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, {7'b0, 2'b01, 2'b01, 1'b0}));
      tbl.push_back(mk("fwd_off",6'd0, 6'd0, 6'd3, 6'd3, 6'd0, 6'd3, 6'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      tbl.push_back(mk("lw_rs2", 6'd1, 6'd7, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_LW));
      tbl.push_back(mk("lw_rs1", 6'd7, 6'd2, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_LW));
      tbl.push_back(mk("lw_rd0", 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      tbl.push_back(mk("lw_nold",6'd7, 6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      tbl.push_back(mk("lw_br",  6'd1, 6'd7, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, E_BR));
      tbl.push_back(mk("br",     6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, E_BR));
      tbl.push_back(mk("mem_hit",6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, E_NONE));
      tbl.push_back(mk("hit_run",6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i]);
      end

      // Three-cycle memory wait then completion
      for (int i = 0; i < 3; i++) step(mc("mem_wait", 1'b0, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("mem_done", 1'b0, 1'b1, 1'b1, 1'b0, E_NONE));
      step(mc("mem_run",  1'b0, 1'b0, 1'b0, 1'b0, E_NONE));

      // Branch held behind a memory stall, honoured when the stall clears
      step(mc("br_hold0", 1'b1, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("br_hold1", 1'b1, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("br_rel",   1'b1, 1'b1, 1'b1, 1'b0, E_BR));
      step(mc("br_idle",  1'b0, 1'b0, 1'b0, 1'b0, E_NONE));

      // Timeout after four wait cycles, absorbing, cleared only by reset
      for (int i = 0; i < 5; i++) step(mc("tmo_wait", 1'b0, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("tmo_rdy",  1'b0, 1'b0, 1'b1, 1'b0, E_TMO));
      step(mc("tmo_idle", 1'b0, 1'b0, 1'b0, 1'b0, E_TMO));
      step(mc("tmo_br",   1'b1, 1'b0, 1'b1, 1'b0, E_TMO));
      step(mc("tmo_rst",  1'b0, 1'b0, 1'b0, 1'b1, E_NONE));
      step(mk("rst_lw", 6'd7, 6'd0, 6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 2'b01,
              1'b0, 1'b0, 1'b0, 1'b1, E_LW));
      step(mc("tmo_clr",  1'b0, 1'b0, 1'b0, 1'b0, E_NONE));

      // Reset in the middle of a memory wait returns to RUN
      step(mc("mw_enter", 1'b0, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("mw_wait",  1'b0, 1'b1, 1'b0, 1'b0, E_MEM));
      step(mc("mw_rst",   1'b0, 1'b0, 1'b0, 1'b1, E_NONE));
      step(mc("mw_run",   1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
      step(mc("mw_br",    1'b1, 1'b0, 1'b0, 1'b0, E_BR));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
